// File: rtl/ppe_sched.sv
// Round-robin resource scheduler: a programmable priority encoder picks one requester,
// the grant is held until done/drop/hold-limit, then a one-cycle gap precedes re-arbitration.

module ppe #(
    parameter int N     = 8,
    parameter int LOG_N = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [LOG_N-1:0] p_enc_i,
    output logic [N-1:0]     gnt_o
);

    logic [LOG_N-1:0] idx;

    // Scan from lowest to highest priority so the requester nearest p_enc_i is assigned last and wins.
    always_comb begin
        gnt_o = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = p_enc_i + LOG_N'(i);
            if (req_i[idx]) begin
                gnt_o = {{(N-1){1'b0}}, 1'b1} << idx;
            end
        end
    end

endmodule

module ppe_sched #(
    parameter int N        = 8,
    parameter int LOG_N    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     done_i,
    output logic [N-1:0]     gnt_o,
    output logic [LOG_N-1:0] gnt_id_o,
    output logic             gnt_valid_o,
    output logic             timeout_o,
    output logic [LOG_N-1:0] ptr_o
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic [1:0] {IDLE, ARB, BUSY, GAP} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     req_reg_q, req_reg_d;
    logic [LOG_N-1:0] ptr_q, ptr_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [LOG_N-1:0] gnt_id_q, gnt_id_d;
    logic             timeout_q, timeout_d;

    logic [N-1:0]     ppe_gnt;
    logic [LOG_N-1:0] ppe_id;
    logic             rel_done, rel_drop, rel_limit, release_now;

    ppe #(.N(N), .LOG_N(LOG_N)) u_ppe (
        .req_i   (req_reg_q),
        .p_enc_i (ptr_q),
        .gnt_o   (ppe_gnt)
    );

    function automatic logic [LOG_N-1:0] encode(input logic [N-1:0] oh);
        logic [LOG_N-1:0] enc;
        enc = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) enc = LOG_N'(i);
        end
        return enc;
    endfunction

    assign ppe_id      = encode(ppe_gnt);
    assign rel_done    = done_i[gnt_id_q];
    assign rel_drop    = ~req_i[gnt_id_q];
    assign rel_limit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    assign release_now = rel_done | rel_drop | rel_limit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            req_reg_q  <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_reg_q  <= req_reg_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_reg_d  = req_reg_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|req_i) begin
                    req_reg_d = req_i;
                    state_d   = ARB;
                end
            end
            ARB: begin
                gnt_d      = ppe_gnt;
                gnt_id_d   = ppe_id;
                ptr_d      = ppe_id + LOG_N'(1);
                hold_cnt_d = '0;
                state_d    = BUSY;
            end
            BUSY: begin
                hold_cnt_d = hold_cnt_q + HW'(1);
                if (release_now) begin
                    gnt_d     = '0;
                    timeout_d = rel_limit & ~rel_done & ~rel_drop;
                    state_d   = GAP;
                end
            end
            GAP: begin
                gnt_d = '0;
                if (|req_i) begin
                    req_reg_d = req_i;
                    state_d   = ARB;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_o       = gnt_q;
        gnt_id_o    = gnt_id_q;
        gnt_valid_o = (state_q == BUSY);
        timeout_o   = timeout_q;
        ptr_o       = ptr_q;
    end

endmodule

// File: tb/tb_ppe_sched.sv
// Directed bench for ppe_sched (N=8, MAX_HOLD=4): latency, round-robin order,
// pointer wrap, hold-limit timeout, ignored foreign done and asynchronous reset.

module tb_ppe_sched;

    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] gnt;
    logic [2:0] gntId;
    logic       gntValid;
    logic       timeout;
    logic [2:0] ptr;

    int checkCount = 0;
    int errorCount = 0;

    ppe_sched #(.N(8), .LOG_N(3), .MAX_HOLD(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .req_i       (req),
        .done_i      (done),
        .gnt_o       (gnt),
        .gnt_id_o    (gntId),
        .gnt_valid_o (gntValid),
        .timeout_o   (timeout),
        .ptr_o       (ptr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] d);
        req  = r;
        done = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advances until a grant is held, bounded so a stuck DUT still reaches the summary.
    task automatic waitGrant(output int cycles);
        cycles = 0;
        while (cycles < 20) begin
            step();
            cycles++;
            if (gntValid === 1'b1) break;
        end
        checkOutput("grant_seen", 32'(gntValid), 32'd1);
    endtask

    initial begin
        int cyc;
        int held;
        int exp;

        rstN = 1'b0;
        applyStimulus(8'h00, 8'h00);
        #12;
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_valid", 32'(gntValid), 32'd0);
        checkOutput("rst_ptr", 32'(ptr), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        checkOutput("rst_id", 32'(gntId), 32'd0);
        rstN = 1'b1;
        step();

        // Single requester 0: two-cycle grant latency.
        applyStimulus(8'h01, 8'h00);
        step();
        checkOutput("lat_gnt_after_1", 32'(gnt), 32'h0);
        step();
        checkOutput("lat_gnt", 32'(gnt), 32'h01);
        checkOutput("lat_id", 32'(gntId), 32'd0);
        checkOutput("lat_ptr", 32'(ptr), 32'd1);
        checkOutput("lat_valid", 32'(gntValid), 32'd1);
        applyStimulus(8'h00, 8'h00);
        step();
        checkOutput("drop_gnt", 32'(gnt), 32'h0);
        step();
        step();

        // Round robin across all requesters from ptr 0.
        rstN = 1'b0;
        #2;
        rstN = 1'b1;
        applyStimulus(8'hFF, 8'h00);
        for (int k = 0; k < 9; k++) begin
            exp = k % 8;
            waitGrant(cyc);
            checkOutput($sformatf("rr_gap_%0d", k), 32'(cyc), 32'd2);
            checkOutput($sformatf("rr_id_%0d", k), 32'(gntId), 32'(exp));
            checkOutput($sformatf("rr_gnt_%0d", k), 32'(gnt), 32'(8'h01 << exp));
            checkOutput($sformatf("rr_ptr_%0d", k), 32'(ptr), 32'((exp + 1) % 8));
            applyStimulus(8'hFF, 8'h01 << exp);
            step();
            applyStimulus(8'hFF, 8'h00);
            checkOutput($sformatf("rr_rel_%0d", k), 32'(gnt), 32'h0);
        end
        applyStimulus(8'h00, 8'h00);
        step();
        step();

        // Move ptr to 5, then 5 beats 0; afterwards ptr 6 makes 0 next.
        applyStimulus(8'h10, 8'h00);
        waitGrant(cyc);
        checkOutput("p5_setup_id", 32'(gntId), 32'd4);
        checkOutput("p5_setup_ptr", 32'(ptr), 32'd5);
        applyStimulus(8'h00, 8'h00);
        step();
        applyStimulus(8'h21, 8'h00);
        waitGrant(cyc);
        checkOutput("p5_id", 32'(gntId), 32'd5);
        checkOutput("p5_ptr", 32'(ptr), 32'd6);
        applyStimulus(8'h21, 8'h20);
        step();
        applyStimulus(8'h21, 8'h00);
        waitGrant(cyc);
        checkOutput("p6_id", 32'(gntId), 32'd0);
        checkOutput("p6_gnt", 32'(gnt), 32'h01);
        checkOutput("p6_ptr", 32'(ptr), 32'd1);
        applyStimulus(8'h00, 8'h00);
        step();
        step();
        step();

        // Hold limit with a lone persistent requester 2.
        applyStimulus(8'h04, 8'h00);
        waitGrant(cyc);
        held = (gnt == 8'h04) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gnt == 8'h04) held++;
            else break;
        end
        checkOutput("hold_cycles", 32'(held), 32'd4);
        checkOutput("hold_timeout", 32'(timeout), 32'd1);
        checkOutput("hold_rel_gnt", 32'(gnt), 32'h0);
        step();
        checkOutput("hold_timeout_pulse", 32'(timeout), 32'd0);
        step();
        checkOutput("hold_regrant", 32'(gnt), 32'h04);
        applyStimulus(8'h00, 8'h00);
        step();
        checkOutput("drop_no_timeout", 32'(timeout), 32'd0);
        step();
        step();

        // Grantee 3: foreign done ignored; own done coinciding with limit gives no timeout.
        applyStimulus(8'h08, 8'h00);
        waitGrant(cyc);
        checkOutput("g3_gnt", 32'(gnt), 32'h08);
        applyStimulus(8'h08, 8'h40);
        step();
        checkOutput("g3_foreign_done", 32'(gnt), 32'h08);
        applyStimulus(8'h08, 8'h00);
        step();
        step();
        checkOutput("g3_still_held", 32'(gnt), 32'h08);
        applyStimulus(8'h08, 8'h08);
        step();
        checkOutput("g3_rel_gnt", 32'(gnt), 32'h0);
        checkOutput("g3_rel_valid", 32'(gntValid), 32'd0);
        checkOutput("g3_no_timeout", 32'(timeout), 32'd0);
        applyStimulus(8'h00, 8'h00);
        step();
        step();

        // Asynchronous reset while requester 6 is granted.
        applyStimulus(8'h40, 8'h00);
        waitGrant(cyc);
        checkOutput("r6_id", 32'(gntId), 32'd6);
        checkOutput("r6_ptr", 32'(ptr), 32'd7);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_gnt", 32'(gnt), 32'h0);
        checkOutput("async_valid", 32'(gntValid), 32'd0);
        checkOutput("async_ptr", 32'(ptr), 32'd0);
        applyStimulus(8'h80, 8'h00);
        #3;
        rstN = 1'b1;
        waitGrant(cyc);
        checkOutput("post_rst_lat", 32'(cyc), 32'd2);
        checkOutput("post_rst_gnt", 32'(gnt), 32'h80);
        checkOutput("post_rst_id", 32'(gntId), 32'd7);
        checkOutput("post_rst_ptr", 32'(ptr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
